// File: rtl/shift_seq_unit_pkg.sv
// Shared definitions for the sequential barrel-shift unit: defaults, op and FSM encodings.
package shift_seq_unit_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SHW   = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_unit_stage.sv
// One conditional shift-by-2^k stage; the unit reuses it once per clock with k from its counter.
module shift_seq_unit_stage
  import shift_seq_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   k,
  input  logic             enable,
  input  op_e              op,
  output logic [WIDTH-1:0] shifted_c
);

  logic [SHW:0] amt;

  assign amt = (SHW+1)'(1) << k;

  always_comb begin
    shifted_c = value;
    if (enable) begin
      case (op)
        OP_SLL:  shifted_c = value << amt;
        OP_SRL:  shifted_c = value >> amt;
        OP_SRA:  shifted_c = WIDTH'($signed(value) >>> amt);
        default: shifted_c = value;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: accepts one operation, applies one log2 stage per clock, holds the result until taken.
module shift_seq_unit
  import shift_seq_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);

  state_e           state, state_d;
  logic [SHW-1:0]   k, k_d;
  logic [WIDTH-1:0] result, result_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] stage_c;

  shift_seq_unit_stage #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_stage (
    .value     (result),
    .k         (k),
    .enable    (shamt_q[k]),
    .op        (op_q),
    .shifted_c (stage_c)
  );

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign data_out  = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      result  <= '0;
      shamt_q <= '0;
      op_q    <= OP_SLL;
    end else begin
      state   <= state_d;
      k       <= k_d;
      result  <= result_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state;
    k_d      = k;
    result_d = result;
    shamt_d  = shamt_q;
    op_d     = op_q;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          result_d = data_in;
          shamt_d  = shamt;
          op_d     = op_e'(op);
          k_d      = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        result_d = stage_c;
        // k parks on the last stage instead of wrapping
        if (k == SHW'(SHW - 1)) begin
          state_d = DONE;
        end else begin
          k_d = k + SHW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
